// File: rtl/sap1_pkg.sv
// Shared SAP-1 definitions: bus widths, loader states and opcode constants.
package sap1_pkg;

  localparam int SAP1_ADDR_W = 4;
  localparam int SAP1_DATA_W = 8;
  localparam int SAP1_DEPTH  = 16;

  // Program loader states.
  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    CHECK,
    DONE,
    ERR
  } loader_state_e;

  // SAP-1 opcodes (upper nibble of an instruction byte).
  localparam logic [3:0] OP_LDA = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

endpackage

// File: rtl/sap1_ram.sv
// SAP-1 16x8 program RAM: synchronous write port for the loader,
// combinational read port for the CPU datapath. Contents survive reset.
module sap1_ram
  import sap1_pkg::*;
#(
  parameter int ADDR_W = SAP1_ADDR_W,
  parameter int DATA_W = SAP1_DATA_W
) (
  input  logic              CLK,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // Write one word per strobed cycle; no reset so a program outlives RST.
  always_ff @(posedge CLK) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sap1_prog_loader.sv
// SAP-1 program loader: streams 16 bytes into program RAM, verifies a
// trailing two's-complement checksum and releases the CPU from clear.
module sap1_prog_loader
  import sap1_pkg::*;
#(
  parameter int ADDR_W = SAP1_ADDR_W,
  parameter int DATA_W = SAP1_DATA_W,
  parameter int DEPTH  = SAP1_DEPTH
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              cpu_clr,
  output logic              done,
  output logic              err
);

  loader_state_e     state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] sum_q, sum_d;
  logic              ram_we_q, ram_we_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
  logic              cpu_clr_q, cpu_clr_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic              accept;
  logic [DATA_W-1:0] sum_next;
  logic              last_byte;

  assign in_ready  = (state_q == LOAD) || (state_q == CHECK);
  assign accept    = in_valid && in_ready;
  assign sum_next  = sum_q + in_data;
  assign last_byte = (cnt_q == ADDR_W'(DEPTH - 1));

  // State and output registers; reset holds the CPU in clear.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      sum_q       <= '0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      cpu_clr_q   <= 1'b1;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sum_q       <= sum_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      cpu_clr_q   <= cpu_clr_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  // Next-state: start only matters outside an image; the checksum decides DONE/ERR.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE, ERR: if (start) state_d = LOAD;
      LOAD:            if (accept && last_byte) state_d = CHECK;
      CHECK:           if (accept) state_d = (sum_next == '0) ? DONE : ERR;
      default:         state_d = IDLE;
    endcase
  end

  // Datapath and status: write accepted bytes, accumulate the sum, and
  // derive the status flags from the state being entered.
  always_comb begin
    cnt_d       = cnt_q;
    sum_d       = sum_q;
    ram_we_d    = 1'b0;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    case (state_q)
      IDLE, DONE, ERR: begin
        if (start) begin
          cnt_d = '0;
          sum_d = '0;
        end
      end
      LOAD: begin
        if (accept) begin
          ram_we_d    = 1'b1;
          ram_addr_d  = cnt_q;
          ram_wdata_d = in_data;
          sum_d       = sum_next;
          cnt_d       = cnt_q + 1'b1;
        end
      end
      default: ;
    endcase
    cpu_clr_d = (state_d != DONE);
    done_d    = (state_d == DONE);
    err_d     = (state_d == ERR);
  end

  assign ram_we    = ram_we_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;
  assign cpu_clr   = cpu_clr_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule
